// File: rtl/header_field_extractor.sv
// Passive stream tap: extracts one big-endian header field at a fixed byte offset per packet
// and counts packets that end before the field completes. Optional VLAN skip via HDR_VLAN_SKIP_EN.
module header_field_extractor #(
    parameter int FIELD_SIZE   = 16,
    parameter int FIELD_OFFSET = 18,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  st_valid,
    input  logic                  st_sop,
    input  logic                  st_eop,
    input  logic [31:0]           st_data,
    input  logic [1:0]            st_empty,
    output logic                  valid,
    output logic [FIELD_SIZE-1:0] field,
    output logic [CNT_WIDTH-1:0]  short_count
);

    localparam int FB = FIELD_SIZE / 8;
`ifdef HDR_VLAN_SKIP_EN
    localparam int LIMIT = FIELD_OFFSET + FB + 4;
`else
    localparam int LIMIT = FIELD_OFFSET + FB;
`endif
    localparam int BW = $clog2(LIMIT + 8) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic [BW-1:0]         r_base;
    logic [FIELD_SIZE-1:0] r_shift;
    logic [FIELD_SIZE-1:0] r_field;
    logic                  r_valid;
    logic [CNT_WIDTH-1:0]  r_short;

    state_t                w_next_state;
    logic [BW-1:0]         w_next_base;
    logic [FIELD_SIZE-1:0] w_shift;
    logic [FIELD_SIZE+7:0] w_cat;
    logic                  w_active;
    logic                  w_done;
    logic [1:0]            w_inc;
    logic [CNT_WIDTH:0]    w_sum;
    int                    w_base_i;
    int                    w_nbytes;
    int                    w_idx;
    int                    w_eff_off;
`ifdef HDR_VLAN_SKIP_EN
    logic [15:0]           r_tpid;
    logic [15:0]           w_tpid;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        w_next_state = r_state;
        w_next_base  = r_base;
        w_shift      = r_shift;
        w_cat        = '0;
        w_active     = 1'b0;
        w_done       = 1'b0;
        w_inc        = 2'd0;
        w_base_i     = int'(r_base);
        w_nbytes     = 4;
        w_idx        = 0;
        w_eff_off    = FIELD_OFFSET;
`ifdef HDR_VLAN_SKIP_EN
        w_tpid       = r_tpid;
`endif

        if (st_valid) begin
            if (st_sop) begin
                // A sop while still collecting means the previous packet lost its eop before the field.
                if (r_state == S_COLLECT) w_inc = 2'd1;
                w_active = 1'b1;
                w_base_i = 0;
                w_shift  = '0;
`ifdef HDR_VLAN_SKIP_EN
                w_tpid   = '0;
`endif
            end else if (r_state == S_COLLECT) begin
                w_active = 1'b1;
            end else if (r_state == S_DRAIN && st_eop) begin
                w_next_state = S_IDLE;
                w_next_base  = '0;
            end
        end

        if (w_active) begin
            w_nbytes = st_eop ? 4 - int'(st_empty) : 4;
`ifdef HDR_VLAN_SKIP_EN
            // Bytes 12-13 sit in lanes 0-1 of an aligned beat, so the decision is ready for byte 14 onward.
            if (w_base_i == 12 && w_nbytes >= 2) w_tpid = st_data[31:16];
            if (w_tpid == 16'h8100) w_eff_off = FIELD_OFFSET + 4;
`endif
            for (int k = 0; k < 4; k++) begin
                w_idx = w_base_i + k;
                if (k < w_nbytes && w_idx >= w_eff_off && w_idx < w_eff_off + FB) begin
                    w_cat   = {w_shift, st_data[31-8*k -: 8]};
                    w_shift = w_cat[FIELD_SIZE-1:0];
                end
            end

            if (w_base_i + w_nbytes - 1 >= w_eff_off + FB - 1) begin
                w_done       = 1'b1;
                w_next_state = st_eop ? S_IDLE : S_DRAIN;
                w_next_base  = '0;
            end else if (st_eop) begin
                w_inc        = w_inc + 2'd1;
                w_next_state = S_IDLE;
                w_next_base  = '0;
            end else begin
                w_next_state = S_COLLECT;
                w_next_base  = (w_base_i + 4 <= LIMIT) ? BW'(w_base_i + 4) : BW'(w_base_i);
            end
        end

        w_sum = {1'b0, r_short} + (CNT_WIDTH+1)'(w_inc);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_shift <= '0;
            r_field <= '0;
            r_valid <= 1'b0;
            r_short <= '0;
`ifdef HDR_VLAN_SKIP_EN
            r_tpid  <= '0;
`endif
        end else begin
            r_state <= w_next_state;
            r_base  <= w_next_base;
            r_shift <= w_shift;
            r_valid <= w_done;
            if (w_done) r_field <= w_shift;
            r_short <= w_sum[CNT_WIDTH] ? '1 : w_sum[CNT_WIDTH-1:0];
`ifdef HDR_VLAN_SKIP_EN
            r_tpid  <= w_tpid;
`endif
        end
    end

    assign valid       = r_valid;
    assign field       = r_field;
    assign short_count = r_short;

endmodule

// File: tb/tb_header_field_extractor.sv
// Directed self-checking bench for header_field_extractor at default parameters.
module tb_header_field_extractor;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        st_valid, st_sop, st_eop;
    logic [31:0] st_data;
    logic [1:0]  st_empty;
    logic        valid;
    logic [15:0] field;
    logic [15:0] short_count;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    logic [7:0] pkt [0:127];

    header_field_extractor dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .st_valid    (st_valid),
        .st_sop      (st_sop),
        .st_eop      (st_eop),
        .st_data     (st_data),
        .st_empty    (st_empty),
        .valid       (valid),
        .field       (field),
        .short_count (short_count)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) if (valid === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_pkt();
        for (int i = 0; i < 128; i++) pkt[i] = 8'(i);
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_data = '0; st_empty = '0;
    endtask

    task automatic drive_beat(input int b, input logic sop, input logic eop, input logic [1:0] emp);
        st_valid = 1'b1; st_sop = sop; st_eop = eop; st_empty = emp;
        st_data  = {pkt[4*b], pkt[4*b+1], pkt[4*b+2], pkt[4*b+3]};
    endtask

    // Sends pkt[0..len-1]; abort>0 sends only that many beats with no eop. Returns the beat after
    // which valid was seen (-1 none, 99 several pulses, 100 pulse during a gap or after the packet).
    task automatic send_packet(input int len, input int abort, input int gap_beat, input int gap_cyc,
                               output int seen);
        int nb;
        logic eop;
        nb   = (abort > 0) ? abort : (len + 3) / 4;
        seen = -1;
        for (int b = 0; b < nb; b++) begin
            if (b == gap_beat) begin
                for (int g = 0; g < gap_cyc; g++) begin
                    idle_inputs();
                    @(posedge sys_clk); #1;
                    if (valid) seen = 100;
                end
            end
            eop = (abort == 0) && (b == nb - 1);
            drive_beat(b, b == 0, eop, eop ? 2'(nb * 4 - len) : 2'd0);
            @(posedge sys_clk); #1;
            if (valid) seen = (seen == -1) ? b : 99;
        end
        idle_inputs();
        @(posedge sys_clk); #1;
        if (valid) seen = 100;
    endtask

    task automatic run_pkt(input string tag, input int len, input int abort, input int gap_beat,
                           input int gap_cyc, input int exp_beat, input logic [15:0] exp_field,
                           input logic [15:0] exp_short);
        int seen, p0;
        p0 = pulse_cnt;
        send_packet(len, abort, gap_beat, gap_cyc, seen);
        check({tag, "_lat"}, 32'(seen), 32'(exp_beat));
        check({tag, "_field"}, 32'(field), 32'(exp_field));
        check({tag, "_short"}, 32'(short_count), 32'(exp_short));
        check({tag, "_pulses"}, 32'(pulse_cnt - p0), (exp_beat >= 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_field", 32'(field), 32'd0);
        check("rst_short", 32'(short_count), 32'd0);
        reset_n = 1'b1;
        @(posedge sys_clk); #1;

        fill_pkt(); pkt[18] = 8'hBE; pkt[19] = 8'hEF;
        run_pkt("t1", 64, 0, -1, 0, 4, 16'hBEEF, 16'd0);
        run_pkt("t2_gap", 64, 0, 4, 3, 4, 16'hBEEF, 16'd0);

        fill_pkt();
        run_pkt("t3_short18", 18, 0, -1, 0, -1, 16'hBEEF, 16'd1);
        pkt[18] = 8'h12; pkt[19] = 8'h34;
        run_pkt("t3_good", 64, 0, -1, 0, 4, 16'h1234, 16'd1);

        fill_pkt();
        run_pkt("t4_abortA", 64, 2, -1, 0, -1, 16'h1234, 16'd1);
        pkt[18] = 8'hA5; pkt[19] = 8'hA5;
        run_pkt("t4_B", 64, 0, -1, 0, 4, 16'hA5A5, 16'd2);

        fill_pkt();
        pkt[12] = 8'h81; pkt[13] = 8'h00;
        pkt[18] = 8'h11; pkt[19] = 8'h11;
        pkt[22] = 8'h56; pkt[23] = 8'h78;
`ifdef HDR_VLAN_SKIP_EN
        run_pkt("t5_vlan", 64, 0, -1, 0, 5, 16'h5678, 16'd2);
`else
        run_pkt("t5_novlan", 64, 0, -1, 0, 4, 16'h1111, 16'd2);
`endif

        fill_pkt(); pkt[18] = 8'hCA; pkt[19] = 8'hFE;
        run_pkt("edge20", 20, 0, -1, 0, 4, 16'hCAFE, 16'd2);
        fill_pkt(); pkt[18] = 8'h99; pkt[19] = 8'h88;
        run_pkt("edge19", 19, 0, -1, 0, -1, 16'hCAFE, 16'd3);
        run_pkt("sop_eop4", 4, 0, -1, 0, -1, 16'hCAFE, 16'd4);

        // Reset in the middle of a packet, then the remaining beats arrive without a sop.
        begin
            int p0;
            p0 = pulse_cnt;
            fill_pkt(); pkt[18] = 8'h77; pkt[19] = 8'h66;
            for (int b = 0; b < 3; b++) begin
                drive_beat(b, b == 0, 1'b0, 2'd0);
                @(posedge sys_clk); #1;
            end
            reset_n = 1'b0;
            #1;
            check("t6_rst_valid", 32'(valid), 32'd0);
            check("t6_rst_field", 32'(field), 32'd0);
            check("t6_rst_short", 32'(short_count), 32'd0);
            @(posedge sys_clk); #1;
            reset_n = 1'b1;
            for (int b = 3; b < 16; b++) begin
                drive_beat(b, 1'b0, b == 15, 2'd0);
                @(posedge sys_clk); #1;
            end
            idle_inputs();
            @(posedge sys_clk); #1;
            check("t6_no_pulse", 32'(pulse_cnt - p0), 32'd0);
            pkt[18] = 8'h31; pkt[19] = 8'h41;
            run_pkt("t6_next", 64, 0, -1, 0, 4, 16'h3141, 16'd0);
        end

        // Back-to-back 4-byte packets, each short; count must stop at all-ones.
        begin
            st_valid = 1'b1; st_sop = 1'b1; st_eop = 1'b1; st_empty = 2'd0; st_data = 32'h0;
            repeat (65534) @(posedge sys_clk);
            #1;
            check("sat_fffe", 32'(short_count), 32'h0000FFFE);
            repeat (7) @(posedge sys_clk);
            #1;
            check("sat_ffff", 32'(short_count), 32'h0000FFFF);
            idle_inputs();
            @(posedge sys_clk); #1;
            check("sat_field_held", 32'(field), 32'h00003141);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
